serial_subtractor_4bit: RTL
===========================

SERIAL_SUBTRACTOR_4BIT -- requirements
Module: serial_subtractor_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 Port: start  input  1  request to begin one subtraction; sampled on rising edge of clk.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on the edge that accepts start.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on the edge that accepts start.
REQ-007 Port: bin  input  1  borrow-in; sampled only on the edge that accepts start.
REQ-008 Port: diff  output  WIDTH  registered result a - b - bin, modulo 2^WIDTH.
REQ-009 Port: bout  output  1  registered borrow-out; 1 when a < b + bin (unsigned).
REQ-010 Port: busy  output  1  high while a subtraction is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when diff/bout become valid.

Function
REQ-012 Three states SHALL exist: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 SHALL capture a, b and bin into internal shift/borrow registers, clear the bit counter, and move to SHIFT.
REQ-014 SHIFT: each cycle SHALL process one bit, LSB first, with a single full-subtractor cell: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 Each computed d SHALL shift into the diff result register from the MSB end, so that after WIDTH bits diff[0] holds bit 0.
REQ-016 After exactly WIDTH SHIFT cycles the state SHALL move to DONE, with bout = final br.
REQ-017 Latency: if start is accepted on edge N, done SHALL be high during the cycle following edge N+WIDTH.
REQ-018 DONE: done=1 for exactly one cycle; next state is IDLE, or SHIFT if start=1 in that cycle (back-to-back, new operands captured).
REQ-019 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-020 start SHALL be ignored while in SHIFT; a, b, bin changes during SHIFT SHALL not affect the result.
REQ-021 diff and bout SHALL hold their last completed values from DONE until the next accepted start; partial values during SHIFT are not guaranteed.
REQ-022 Operand values 0 and 2^WIDTH-1 and bin=1 SHALL wrap modulo 2^WIDTH without special handling.

Reset
REQ-023 rst_n=0 SHALL asynchronously force state IDLE, diff=0, bout=0, busy=0, done=0, counter=0 and internal registers=0.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow release.
REQ-025 The first rising edge with rst_n=1 SHALL be able to accept start.

Configuration
REQ-026 Macro SUB_OVERFLOW_EN: when defined, the module SHALL add output port ovf (1 bit, registered, reset 0) = signed two's-complement overflow of a - b - bin, i.e. (a_msb != b_msb) && (diff_msb != a_msb), updated with done.
REQ-027 When SUB_OVERFLOW_EN is undefined, port ovf and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=4)
REQ-028 a=1011, b=0111, bin=0, start pulse -> diff=0100, bout=0, done high 5 cycles after accepting edge, busy high for 4 cycles.
REQ-029 a=0101, b=1111, bin=1 -> diff=0101, bout=1; a=1001, b=1001, bin=0 -> diff=0000, bout=0.
REQ-030 With SUB_OVERFLOW_EN: a=0111, b=1000, bin=0 -> diff=1111, bout=1, ovf=1; a=0011, b=0001 -> diff=0010, ovf=0.
REQ-031 start re-asserted with different operands during SHIFT -> ignored; result of first operation unchanged; done pulses once.
REQ-032 rst_n low during second SHIFT cycle -> busy=0, diff=0, bout=0 immediately; no done; subsequent start of 1011-0111 yields 0100.
REQ-033 start held high in DONE cycle with a=1111, b=0001 -> immediate SHIFT, next done shows diff=1110, bout=0.

Source files
------------

// File: rtl/serial_subtractor_4bit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial subtractor: computes diff = a - b - bin (mod 2^WIDTH) and the
// unsigned borrow-out, one bit per clock, LSB first, through a single
// full-subtractor cell.
//
// Optional feature macro: SUB_OVERFLOW_EN
//    When defined, adds output ovf (signed two's-complement overflow of the
//    subtraction, registered and updated together with done).
//
// Ports
//    clk    in   rising-edge clock
//    rst_n  in   asynchronous active-low reset
//    start  in   begin a subtraction (accepted in IDLE or DONE)
//    a      in   [WIDTH-1:0] minuend, sampled on the accepting edge
//    b      in   [WIDTH-1:0] subtrahend, sampled on the accepting edge
//    bin    in   borrow-in, sampled on the accepting edge
//    diff   out  [WIDTH-1:0] registered result
//    bout   out  registered borrow-out (a < b + bin, unsigned)
//    busy   out  high while bits are being shifted
//    done   out  one-cycle pulse when diff/bout become valid
//    ovf    out  (SUB_OVERFLOW_EN only) signed overflow flag
// -----------------------------------------------------------------------------
module serial_subtractor_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
`ifdef SUB_OVERFLOW_EN
   output logic             done,
   output logic             ovf
`else
   output logic             done
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // One full-subtractor cell: returns {borrow_next, difference_bit}.
   function automatic logic [1:0] full_sub(input logic ai, input logic bi, input logic bri);
      logic d;
      logic brn;
      d   = ai ^ bi ^ bri;
      brn = (~ai & bi) | (~(ai ^ bi) & bri);
      return {brn, d};
   endfunction

   state_t           state_r;
   logic [WIDTH-1:0] a_sh_r;
   logic [WIDTH-1:0] b_sh_r;
   logic             br_r;
   logic [CW-1:0]    cnt_r;
`ifdef SUB_OVERFLOW_EN
   logic             a_msb_r;
   logic             b_msb_r;
`endif

   logic [1:0]       fs_s;
   logic             load_s;

   // Full-subtractor on the current LSBs of the operand shift registers.
   always_comb begin
      fs_s = full_sub(a_sh_r[0], b_sh_r[0], br_r);
   end

   // A new operation may be accepted whenever no subtraction is in flight.
   always_comb begin
      load_s = 1'b0;
      if (start && (state_r != SHIFT)) begin
         load_s = 1'b1;
      end else begin
         load_s = 1'b0;
      end
   end

   // Control FSM, operand shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_sh_r  <= '0;
         b_sh_r  <= '0;
         br_r    <= 1'b0;
         cnt_r   <= '0;
         diff    <= '0;
         bout    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else if (load_s) begin
         // Accepted from IDLE or from DONE (back-to-back); diff/bout keep
         // the previous result until bits start arriving.
         state_r <= SHIFT;
         a_sh_r  <= a;
         b_sh_r  <= b;
         br_r    <= bin;
         cnt_r   <= '0;
         busy    <= 1'b1;
         done    <= 1'b0;
`ifdef SUB_OVERFLOW_EN
         a_msb_r <= a[WIDTH-1];
         b_msb_r <= b[WIDTH-1];
`endif
      end else begin
         case (state_r)
            IDLE: begin
               busy <= 1'b0;
               done <= 1'b0;
            end
            SHIFT: begin
               a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
               b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
               br_r   <= fs_s[1];
               // New bits enter at the MSB so bit 0 ends up at diff[0].
               diff   <= {fs_s[0], diff[WIDTH-1:1]};
               if (cnt_r == LAST_BIT) begin
                  state_r <= DONE;
                  bout    <= fs_s[1];
                  busy    <= 1'b0;
                  done    <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                  // fs_s[0] is the final result MSB.
                  ovf     <= (a_msb_r != b_msb_r) && (fs_s[0] != a_msb_r);
`endif
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            DONE: begin
               state_r <= IDLE;
               done    <= 1'b0;
               busy    <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

endmodule
